// File: rtl/psram_bus_arbiter.sv
// psram_bus_arbiter: shares the PSRAM controller command/data port between
// the framebuffer line reader (read bursts, priority) and the SPI pixel
// writer (write bursts). Each grant runs a full burst followed by a
// mandatory idle gap before the next command may issue.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_mem_init_done        controller calibration complete; gates grants
//   i_rd_req/i_rd_addr     reader request and burst address
//   o_rd_gnt               pulse when the read command issues
//   o_rd_data(_valid)      read beats forwarded with zero latency
//   i_wr_req/i_wr_addr     writer request and burst address
//   i_wr_data/i_wr_mask    first-word-fall-through write beat and byte mask
//   o_wr_gnt               pulse when the write command issues
//   o_wr_data_ack          pops one write beat from the writer
//   o_mem_*                command, address, write data/mask to controller
//   i_mem_rd_data(_valid)  read data from controller
//   o_err                  sticky read-timeout flag
//
// Optional build macro PSRAM_ARB_WR_STARVE_GUARD_EN: after MAX_RD_STREAK
// consecutive read grants with a write pending, the next decision goes to
// the writer. Without it, reads always win and no streak counter is built.
//
// Command, grant and data outputs are Mealy outputs of the state register
// so that a command issues in the same cycle the request is seen in IDLE.
module psram_bus_arbiter #(
  parameter int unsigned BURST_BEATS   = 4,
  parameter int unsigned CMD_GAP       = 14,
  parameter int unsigned RD_TIMEOUT    = 64,
  parameter int unsigned MAX_RD_STREAK = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_init_done,
  input  logic        i_rd_req,
  input  logic [20:0] i_rd_addr,
  output logic        o_rd_gnt,
  output logic [63:0] o_rd_data,
  output logic        o_rd_data_valid,
  input  logic        i_wr_req,
  input  logic [20:0] i_wr_addr,
  input  logic [63:0] i_wr_data,
  input  logic [7:0]  i_wr_mask,
  output logic        o_wr_gnt,
  output logic        o_wr_data_ack,
  output logic        o_mem_cmd,
  output logic        o_mem_cmd_en,
  output logic [20:0] o_mem_addr,
  output logic [63:0] o_mem_wr_data,
  output logic [7:0]  o_mem_data_mask,
  input  logic [63:0] i_mem_rd_data,
  input  logic        i_mem_rd_data_valid,
  output logic        o_err
);

  localparam int unsigned BEAT_W = $clog2(BURST_BEATS) + 1;
  localparam int unsigned GAP_W  = $clog2(CMD_GAP) + 1;
  localparam int unsigned TO_W   = $clog2(RD_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_GAP      = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [TO_W-1:0]     cyc_q, cyc_d;
  logic                err_q, err_d;
  logic                starve_c;

`ifdef PSRAM_ARB_WR_STARVE_GUARD_EN
  localparam int unsigned STREAK_W = $clog2(MAX_RD_STREAK) + 1;
  logic [STREAK_W-1:0] streak_q, streak_d;

  // Writer has waited through a full streak of read grants: it takes the next slot.
  assign starve_c = i_wr_req && (streak_q >= STREAK_W'(MAX_RD_STREAK));
`else
  logic unused_max_rd_streak;

  assign starve_c             = 1'b0;
  assign unused_max_rd_streak = (MAX_RD_STREAK != 0);
`endif

  // Next-state and burst sequencing; outputs stay 0 while reset is held.
  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    gap_d           = gap_q;
    cyc_d           = cyc_q;
    err_d           = err_q;
`ifdef PSRAM_ARB_WR_STARVE_GUARD_EN
    streak_d        = streak_q;
`endif
    o_rd_gnt        = 1'b0;
    o_rd_data       = '0;
    o_rd_data_valid = 1'b0;
    o_wr_gnt        = 1'b0;
    o_wr_data_ack   = 1'b0;
    o_mem_cmd       = 1'b0;
    o_mem_cmd_en    = 1'b0;
    o_mem_addr      = '0;
    o_mem_wr_data   = '0;
    o_mem_data_mask = '0;
    o_err           = 1'b0;

    if (!i_rst) begin
      o_err = err_q;
      unique case (state_q)
        ST_IDLE: begin
          if (i_mem_init_done) begin
            if (i_rd_req && !starve_c) begin
              o_mem_cmd_en = 1'b1;
              o_mem_cmd    = 1'b0;
              o_mem_addr   = i_rd_addr;
              o_rd_gnt     = 1'b1;
              beat_d       = '0;
              cyc_d        = TO_W'(1);
              state_d      = ST_RD_WAIT;
`ifdef PSRAM_ARB_WR_STARVE_GUARD_EN
              streak_d     = i_wr_req ? streak_q + STREAK_W'(1) : '0;
`endif
            end else if (i_wr_req) begin
              o_mem_cmd_en    = 1'b1;
              o_mem_cmd       = 1'b1;
              o_mem_addr      = i_wr_addr;
              o_wr_gnt        = 1'b1;
              o_wr_data_ack   = 1'b1;
              o_mem_wr_data   = i_wr_data;
              o_mem_data_mask = i_wr_mask;
              beat_d          = BEAT_W'(1);
              state_d         = ST_WR_BURST;
`ifdef PSRAM_ARB_WR_STARVE_GUARD_EN
              streak_d        = '0;
`endif
            end
          end
        end

        ST_RD_WAIT: begin
          // cyc_q holds cycles elapsed since the read command.
          cyc_d = cyc_q + TO_W'(1);
          if (i_mem_rd_data_valid) begin
            o_rd_data       = i_mem_rd_data;
            o_rd_data_valid = 1'b1;
            beat_d          = beat_q + BEAT_W'(1);
          end
          if (i_mem_rd_data_valid && (beat_q == BEAT_W'(BURST_BEATS - 1))) begin
            gap_d   = '0;
            state_d = ST_GAP;
          end else if (cyc_q == TO_W'(RD_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end

        ST_WR_BURST: begin
          // Beats 1..N-1 stream back to back; one trailing cycle lets the
          // controller retire the last beat before the gap starts counting.
          if (beat_q < BEAT_W'(BURST_BEATS)) begin
            o_wr_data_ack   = 1'b1;
            o_mem_wr_data   = i_wr_data;
            o_mem_data_mask = i_wr_mask;
            beat_d          = beat_q + BEAT_W'(1);
          end else begin
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end

        ST_GAP: begin
          if (gap_q == GAP_W'(CMD_GAP - 1)) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      gap_q    <= '0;
      cyc_q    <= '0;
      err_q    <= 1'b0;
`ifdef PSRAM_ARB_WR_STARVE_GUARD_EN
      streak_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
      cyc_q    <= cyc_d;
      err_q    <= err_d;
`ifdef PSRAM_ARB_WR_STARVE_GUARD_EN
      streak_q <= streak_d;
`endif
    end
  end

endmodule

// File: tb/tb_psram_bus_arbiter.sv
// Bench for psram_bus_arbiter: expected commands, read beats and write beats
// are queued when stimulus is applied and popped by a negedge monitor.
module tb_psram_bus_arbiter;

  localparam int unsigned BURST_BEATS = 4;
  localparam int unsigned CMD_GAP     = 14;
  localparam int unsigned RD_TIMEOUT  = 64;
`ifdef PSRAM_ARB_WR_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        i_rst;
  logic        i_mem_init_done;
  logic        i_rd_req;
  logic [20:0] i_rd_addr;
  logic        o_rd_gnt;
  logic [63:0] o_rd_data;
  logic        o_rd_data_valid;
  logic        i_wr_req;
  logic [20:0] i_wr_addr;
  logic [63:0] i_wr_data;
  logic [7:0]  i_wr_mask;
  logic        o_wr_gnt;
  logic        o_wr_data_ack;
  logic        o_mem_cmd;
  logic        o_mem_cmd_en;
  logic [20:0] o_mem_addr;
  logic [63:0] o_mem_wr_data;
  logic [7:0]  o_mem_data_mask;
  logic [63:0] i_mem_rd_data;
  logic        i_mem_rd_data_valid;
  logic        o_err;

  psram_bus_arbiter dut (
    .i_clk               (clk),
    .i_rst               (i_rst),
    .i_mem_init_done     (i_mem_init_done),
    .i_rd_req            (i_rd_req),
    .i_rd_addr           (i_rd_addr),
    .o_rd_gnt            (o_rd_gnt),
    .o_rd_data           (o_rd_data),
    .o_rd_data_valid     (o_rd_data_valid),
    .i_wr_req            (i_wr_req),
    .i_wr_addr           (i_wr_addr),
    .i_wr_data           (i_wr_data),
    .i_wr_mask           (i_wr_mask),
    .o_wr_gnt            (o_wr_gnt),
    .o_wr_data_ack       (o_wr_data_ack),
    .o_mem_cmd           (o_mem_cmd),
    .o_mem_cmd_en        (o_mem_cmd_en),
    .o_mem_addr          (o_mem_addr),
    .o_mem_wr_data       (o_mem_wr_data),
    .o_mem_data_mask     (o_mem_data_mask),
    .i_mem_rd_data       (i_mem_rd_data),
    .i_mem_rd_data_valid (i_mem_rd_data_valid),
    .o_err               (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [21:0] cmd_exp[$];
  logic [63:0] rd_exp[$];
  logic [71:0] wr_exp[$];

  // Writer FIFO model: head word is presented, popped on ack.
  logic [63:0] fifo_d [16];
  logic [7:0]  fifo_m [16];
  logic [3:0]  wr_ptr = '0;
  logic [3:0]  wr_wp  = '0;
  assign i_wr_data = fifo_d[wr_ptr];
  assign i_wr_mask = fifo_m[wr_ptr];

  int          cmd_cnt = 0;
  int          cmd_cyc = 0;
  int          ack_cnt = 0;
  logic        mon_en  = 1'b0;
  logic [21:0] m_cmd;
  logic [63:0] m_rd;
  logic [71:0] m_wr;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_mem_cmd_en) begin
        cmd_cnt++;
        cmd_cyc = cyc;
        if (cmd_exp.size() == 0) begin
          chk("cmd_unexpected", 96'(1), 96'(0));
        end else begin
          m_cmd = cmd_exp.pop_front();
          chk("cmd", 96'({o_mem_cmd, o_mem_addr}), 96'(m_cmd));
        end
        chk("gnt", 96'({o_rd_gnt, o_wr_gnt}), o_mem_cmd ? 96'(1) : 96'(2));
      end else begin
        chk("gnt_idle", 96'({o_rd_gnt, o_wr_gnt}), 96'(0));
      end
      if (o_rd_data_valid) begin
        if (rd_exp.size() == 0) begin
          chk("rd_unexpected", 96'(1), 96'(0));
        end else begin
          m_rd = rd_exp.pop_front();
          chk("rd_data", 96'(o_rd_data), 96'(m_rd));
        end
      end
      if (o_wr_data_ack) begin
        ack_cnt++;
        if (wr_exp.size() == 0) begin
          chk("wr_unexpected", 96'(1), 96'(0));
        end else begin
          m_wr = wr_exp.pop_front();
          chk("wr_beat", 96'({o_mem_data_mask, o_mem_wr_data}), 96'(m_wr));
        end
        wr_ptr = wr_ptr + 4'd1;
      end else begin
        chk("wr_idle", 96'({o_mem_data_mask, o_mem_wr_data}), 96'(0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_cmds(input int n, input int budget);
    int k = 0;
    while (cmd_cnt < n && k < budget) begin
      step();
      k++;
    end
    chk("cmd_wait", 96'(cmd_cnt >= n), 96'(1));
  endtask

  task automatic load_fifo(input logic [63:0] base, input logic [7:0] m2, input int n_exp);
    for (int i = 0; i < 4; i++) begin
      fifo_d[wr_wp] = base + 64'(i);
      fifo_m[wr_wp] = (i == 2) ? m2 : 8'h00;
      if (i < n_exp) wr_exp.push_back({fifo_m[wr_wp], fifo_d[wr_wp]});
      wr_wp = wr_wp + 4'd1;
    end
  endtask

  task automatic rd_beats(input int start, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      goto(start + i);
      i_mem_rd_data_valid = 1'b1;
      i_mem_rd_data       = base + 64'(i);
      rd_exp.push_back(base + 64'(i));
    end
    goto(start + n);
    i_mem_rd_data_valid = 1'b0;
    i_mem_rd_data       = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 96'({o_rd_gnt, o_rd_data_valid, o_wr_gnt, o_wr_data_ack, o_mem_cmd,
                  o_mem_cmd_en, o_mem_addr, o_err, o_mem_data_mask}), 96'(0));
    chk({tag, "_wdata"}, 96'(o_mem_wr_data), 96'(0));
    chk({tag, "_rdata"}, 96'(o_rd_data), 96'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, w0, r0, r1, n, ack0;
    bit is_wr;
    for (int i = 0; i < 16; i++) begin
      fifo_d[i] = '0;
      fifo_m[i] = '0;
    end
    i_rst               = 1'b1;
    i_mem_init_done     = 1'b0;
    i_rd_req            = 1'b0;
    i_rd_addr           = '0;
    i_wr_req            = 1'b0;
    i_wr_addr           = '0;
    i_mem_rd_data       = '0;
    i_mem_rd_data_valid = 1'b0;

    // Reset state.
    step();
    mon_en = 1'b1;
    step();
    step();
    chk_all_zero("rst_outs");

    // Both requesters waiting on calibration: nothing may issue.
    i_rst     = 1'b0;
    i_rd_req  = 1'b1;
    i_wr_req  = 1'b1;
    i_rd_addr = 21'h000020;
    i_wr_addr = 21'h001000;
    load_fifo(64'h0123_4567_89AB_C000, 8'h0F, 4);
    repeat (100) step();
    chk("pre_init_cmds", 96'(cmd_cnt), 96'(0));
    chk("err_after_rst", 96'(o_err), 96'(0));

    // Calibration done: read wins the simultaneous request in the same cycle.
    cmd_exp.push_back({1'b0, 21'h000020});
    cmd_exp.push_back({1'b1, 21'h001000});
    i_mem_init_done = 1'b1;
    #1;
    chk("init_rd_grant", 96'({o_mem_cmd_en, o_rd_gnt, o_mem_cmd}), 96'(3'b110));
    c0 = cyc;
    wait_cmds(1, 4);
    goto(c0 + 2);
    i_rd_req = 1'b0;
    rd_beats(c0 + 3, 4, 64'hA0);
    // A stray strobe during the gap must not reach the reader.
    goto(c0 + 8);
    i_mem_rd_data_valid = 1'b1;
    i_mem_rd_data       = 64'hDEAD;
    goto(c0 + 9);
    i_mem_rd_data_valid = 1'b0;
    i_mem_rd_data       = '0;

    // Pending write follows after the read gap.
    wait_cmds(2, 30);
    chk("rd_spacing", 96'(cmd_cyc - (c0 + 6)), 96'(CMD_GAP + 1));
    w0       = cmd_cyc;
    i_wr_req = 1'b0;

    // Next read: only 2 beats come back, so it times out.
    i_rd_addr = 21'h000040;
    i_rd_req  = 1'b1;
    cmd_exp.push_back({1'b0, 21'h000040});
    wait_cmds(3, 30);
    chk("wr_spacing", 96'(cmd_cyc - w0), 96'(BURST_BEATS + CMD_GAP + 1));
    chk("wr_acks", 96'(ack_cnt), 96'(4));
    chk("wr_drained", 96'(wr_exp.size()), 96'(0));
    r0       = cmd_cyc;
    i_rd_req = 1'b0;
    rd_beats(r0 + 2, 2, 64'hB0);
    goto(r0 + RD_TIMEOUT - 1);
    chk("err_early", 96'(o_err), 96'(0));
    goto(r0 + RD_TIMEOUT);
    chk("err_timeout", 96'(o_err), 96'(1));

    // Recovery: a normal read follows the timeout gap.
    i_rd_addr = 21'h000080;
    i_rd_req  = 1'b1;
    cmd_exp.push_back({1'b0, 21'h000080});
    wait_cmds(4, 30);
    chk("to_recover", 96'(cmd_cyc - r0), 96'(RD_TIMEOUT + CMD_GAP));
    r1       = cmd_cyc;
    i_rd_req = 1'b0;
    rd_beats(r1 + 2, 4, 64'hC0);
    chk("err_sticky", 96'(o_err), 96'(1));
    chk("rd_drained", 96'(rd_exp.size()), 96'(0));

    // Read held against a pending write for nine decisions.
    i_wr_addr = 21'h003000;
    load_fifo(64'hFEDC_BA98_7654_D000, 8'hF0, 4);
    i_rd_req = 1'b1;
    i_wr_req = 1'b1;
    n = 4;
    for (int i = 0; i < 9; i++) begin
      is_wr = GUARD && (i == 8);
      cmd_exp.push_back(is_wr ? {1'b1, 21'h003000} : {1'b0, 21'h000080});
      n++;
      wait_cmds(n, 40);
      if (is_wr) begin
        i_wr_req = 1'b0;
        i_rd_req = 1'b0;
      end else begin
        rd_beats(cmd_cyc + 2, 4, 64'hD00 + 64'(i * 16));
      end
    end
    if (!GUARD) begin
      i_rd_req = 1'b0;
      cmd_exp.push_back({1'b1, 21'h003000});
      n++;
      wait_cmds(n, 40);
      i_wr_req = 1'b0;
    end
    goto(cmd_cyc + BURST_BEATS + 2);
    chk("prio_wr_drained", 96'(wr_exp.size()), 96'(0));
    chk("prio_rd_drained", 96'(rd_exp.size()), 96'(0));

    // Reset during write beat 1: burst abandoned, then normal grant.
    i_wr_addr = 21'h002000;
    load_fifo(64'h5555_0000_0000_E000, 8'h00, 1);
    cmd_exp.push_back({1'b1, 21'h002000});
    i_wr_req = 1'b1;
    n++;
    wait_cmds(n, 40);
    w0 = cmd_cyc;
    chk("err_hold", 96'(o_err), 96'(1));
    ack0      = ack_cnt;
    i_rst     = 1'b1;
    i_wr_req  = 1'b0;
    i_rd_req  = 1'b1;
    i_rd_addr = 21'h000060;
    goto(w0 + 2);
    chk_all_zero("rst_mid_wr");
    cmd_exp.push_back({1'b0, 21'h000060});
    goto(w0 + 3);
    i_rst = 1'b0;
    n++;
    wait_cmds(n, 5);
    chk("post_rst_grant", 96'(cmd_cyc - w0), 96'(3));
    chk("err_cleared", 96'(o_err), 96'(0));
    chk("rst_no_acks", 96'(ack_cnt - ack0), 96'(0));
    i_rd_req = 1'b0;
    rd_beats(cmd_cyc + 2, 4, 64'hE0);
    goto(cmd_cyc + 8);
    chk("final_cmd_q", 96'(cmd_exp.size()), 96'(0));
    chk("final_rd_q", 96'(rd_exp.size()), 96'(0));
    chk("final_wr_q", 96'(wr_exp.size()), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
